branch_resolve_unit: RTL

Parametrised, pipelined branch resolution functional unit with multiple independent issue lanes. Each lane evaluates the RISC-V conditional-branch condition (BEQ/BNE/BLT/BGE/BLTU/BGEU), computes JAL/JALR targets and link values, and compares the outcome against the front-end prediction to flag mispredicts. It sits between the issue stage and the complete/retire logic. Per-lane valid/ready handshakes and a global squash replace the single-cycle, never-stall behaviour of the earlier conditional-branch FU.

---
 rtl/branch_resolve_unit_if.sv | 46 ++++
 rtl/branch_resolve_unit.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit_if.sv
// Issue-side and complete-side bundle for the branch resolution unit.
// Per-lane fields are packed [lane][bit] so a lane index selects one operand.
interface branch_resolve_unit_if #(
    parameter int NUM_LANES = 2,
    parameter int XLEN      = 32,
    parameter int TAG_W     = 6,
    parameter int CNT_W     = 32
);
    logic                                squash;
    logic [NUM_LANES-1:0]                in_valid;
    logic [NUM_LANES-1:0]                in_ready;
    logic [NUM_LANES-1:0][1:0]           in_kind;
    logic [NUM_LANES-1:0][2:0]           in_funct3;
    logic [NUM_LANES-1:0][XLEN-1:0]      in_rs1;
    logic [NUM_LANES-1:0][XLEN-1:0]      in_rs2;
    logic [NUM_LANES-1:0][XLEN-1:0]      in_pc;
    logic [NUM_LANES-1:0][XLEN-1:0]      in_imm;
    logic [NUM_LANES-1:0]                in_pred_taken;
    logic [NUM_LANES-1:0][XLEN-1:0]      in_pred_target;
    logic [NUM_LANES-1:0][TAG_W-1:0]     in_tag;
    logic [NUM_LANES-1:0]                out_valid;
    logic [NUM_LANES-1:0]                out_ready;
    logic [NUM_LANES-1:0]                out_take;
    logic [NUM_LANES-1:0][XLEN-1:0]      out_target;
    logic [NUM_LANES-1:0][XLEN-1:0]      out_link;
    logic [NUM_LANES-1:0]                out_mispredict;
    logic [NUM_LANES-1:0]                out_illegal;
    logic [NUM_LANES-1:0][TAG_W-1:0]     out_tag;
    logic [CNT_W-1:0]                    mispredict_count;

    // Issue/retire side: drives ops and consumes results.
    modport master (
        output squash, in_valid, in_kind, in_funct3, in_rs1, in_rs2, in_pc, in_imm,
               in_pred_taken, in_pred_target, in_tag, out_ready,
        input  in_ready, out_valid, out_take, out_target, out_link, out_mispredict,
               out_illegal, out_tag, mispredict_count
    );

    // Functional unit side.
    modport slave (
        input  squash, in_valid, in_kind, in_funct3, in_rs1, in_rs2, in_pc, in_imm,
               in_pred_taken, in_pred_target, in_tag, out_ready,
        output in_ready, out_valid, out_take, out_target, out_link, out_mispredict,
               out_illegal, out_tag, mispredict_count
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// Multi-lane pipelined branch resolution: evaluates the branch at entry,
// then carries the result through an elastic per-lane pipeline.

// One independent lane: combinational resolve plus PIPE_DEPTH elastic stages.
module branch_resolve_lane #(
    parameter int PIPE_DEPTH = 2,
    parameter int XLEN       = 32,
    parameter int TAG_W      = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             squash_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [1:0]       kind_i,
    input  logic [2:0]       funct3_i,
    input  logic [XLEN-1:0]  rs1_i,
    input  logic [XLEN-1:0]  rs2_i,
    input  logic [XLEN-1:0]  pc_i,
    input  logic [XLEN-1:0]  imm_i,
    input  logic             pred_taken_i,
    input  logic [XLEN-1:0]  pred_target_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic             take_o,
    output logic [XLEN-1:0]  target_o,
    output logic [XLEN-1:0]  link_o,
    output logic             mispredict_o,
    output logic             illegal_o,
    output logic [TAG_W-1:0] tag_o
);
    typedef struct packed {
        logic             take;
        logic [XLEN-1:0]  target;
        logic [XLEN-1:0]  link;
        logic             mispredict;
        logic             illegal;
        logic [TAG_W-1:0] tag;
    } res_t;

    res_t                  ev;
    res_t [PIPE_DEPTH-1:0] pay_q, pay_d;
    logic [PIPE_DEPTH-1:0] vld_q, vld_d;
    logic [PIPE_DEPTH-1:0] stage_free;

    // Resolve direction, target, link and mispredict for the op at the lane input.
    always_comb begin
        ev        = '0;
        ev.tag    = tag_i;
        ev.link   = pc_i + XLEN'(4);
        ev.target = (kind_i == 2'b10) ? ((rs1_i + imm_i) & ~XLEN'(1)) : (pc_i + imm_i);
        case (kind_i)
            2'b00: begin
                case (funct3_i)
                    3'b000:  ev.take = (rs1_i == rs2_i);
                    3'b001:  ev.take = (rs1_i != rs2_i);
                    3'b100:  ev.take = ($signed(rs1_i) <  $signed(rs2_i));
                    3'b101:  ev.take = ($signed(rs1_i) >= $signed(rs2_i));
                    3'b110:  ev.take = (rs1_i <  rs2_i);
                    3'b111:  ev.take = (rs1_i >= rs2_i);
                    default: ev.illegal = 1'b1;
                endcase
            end
            2'b01, 2'b10: ev.take = 1'b1;
            default:      ev.illegal = 1'b1;
        endcase
        ev.mispredict = !ev.illegal &&
                        ((ev.take != pred_taken_i) || (ev.take && (ev.target != pred_target_i)));
    end

    // A stage can take new data if it, or any stage above it, is empty, or the tail drains.
    for (genvar i = 0; i < PIPE_DEPTH; i++) begin : g_free
        assign stage_free[i] = out_ready_i | ~(&vld_q[PIPE_DEPTH-1:i]);
    end

    assign in_ready_o = stage_free[0];

    // Next-state of the elastic pipeline; squash only kills valid bits.
    always_comb begin
        vld_d = vld_q;
        pay_d = pay_q;
        if (stage_free[0]) begin
            vld_d[0] = in_valid_i;
            if (in_valid_i) pay_d[0] = ev;
        end
        for (int i = 1; i < PIPE_DEPTH; i++) begin
            if (stage_free[i]) begin
                vld_d[i] = vld_q[i-1];
                if (vld_q[i-1]) pay_d[i] = pay_q[i-1];
            end
        end
        if (squash_i) vld_d = '0;
    end

    // Pipeline registers; reset also zeroes payload so outputs read 0.
    always_ff @(posedge clock) begin
        if (reset) begin
            vld_q <= '0;
            pay_q <= '0;
        end else begin
            vld_q <= vld_d;
            pay_q <= pay_d;
        end
    end

    assign out_valid_o  = vld_q[PIPE_DEPTH-1];
    assign take_o       = pay_q[PIPE_DEPTH-1].take;
    assign target_o     = pay_q[PIPE_DEPTH-1].target;
    assign link_o       = pay_q[PIPE_DEPTH-1].link;
    assign mispredict_o = pay_q[PIPE_DEPTH-1].mispredict;
    assign illegal_o    = pay_q[PIPE_DEPTH-1].illegal;
    assign tag_o        = pay_q[PIPE_DEPTH-1].tag;
endmodule

module branch_resolve_unit #(
    parameter int NUM_LANES  = 2,
    parameter int PIPE_DEPTH = 2,
    parameter int XLEN       = 32,
    parameter int TAG_W      = 6,
    parameter int CNT_W      = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    branch_resolve_unit_if.slave bus
);
    logic [NUM_LANES-1:0]              in_ready;
    logic [NUM_LANES-1:0]              out_valid;
    logic [NUM_LANES-1:0]              out_take;
    logic [NUM_LANES-1:0][XLEN-1:0]    out_target;
    logic [NUM_LANES-1:0][XLEN-1:0]    out_link;
    logic [NUM_LANES-1:0]              out_mispredict;
    logic [NUM_LANES-1:0]              out_illegal;
    logic [NUM_LANES-1:0][TAG_W-1:0]   out_tag;
    logic [NUM_LANES-1:0]              mis_deliver;
    logic [CNT_W-1:0]                  cnt_q, cnt_d;

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        branch_resolve_lane #(
            .PIPE_DEPTH (PIPE_DEPTH),
            .XLEN       (XLEN),
            .TAG_W      (TAG_W)
        ) u_lane (
            .clock         (clock),
            .reset         (reset),
            .squash_i      (bus.squash),
            .in_valid_i    (bus.in_valid[l]),
            .in_ready_o    (in_ready[l]),
            .kind_i        (bus.in_kind[l]),
            .funct3_i      (bus.in_funct3[l]),
            .rs1_i         (bus.in_rs1[l]),
            .rs2_i         (bus.in_rs2[l]),
            .pc_i          (bus.in_pc[l]),
            .imm_i         (bus.in_imm[l]),
            .pred_taken_i  (bus.in_pred_taken[l]),
            .pred_target_i (bus.in_pred_target[l]),
            .tag_i         (bus.in_tag[l]),
            .out_valid_o   (out_valid[l]),
            .out_ready_i   (bus.out_ready[l]),
            .take_o        (out_take[l]),
            .target_o      (out_target[l]),
            .link_o        (out_link[l]),
            .mispredict_o  (out_mispredict[l]),
            .illegal_o     (out_illegal[l]),
            .tag_o         (out_tag[l])
        );
        assign mis_deliver[l] = out_valid[l] & bus.out_ready[l] & out_mispredict[l];
    end

    // Add one per delivering mispredict lane, pinning at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        for (int l = 0; l < NUM_LANES; l++) begin
            if (mis_deliver[l] && (cnt_d != {CNT_W{1'b1}})) cnt_d = cnt_d + CNT_W'(1);
        end
    end

    // Counter survives squash; only reset clears it.
    always_ff @(posedge clock) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign bus.in_ready         = in_ready;
    assign bus.out_valid        = out_valid;
    assign bus.out_take         = out_take;
    assign bus.out_target       = out_target;
    assign bus.out_link         = out_link;
    assign bus.out_mispredict   = out_mispredict;
    assign bus.out_illegal      = out_illegal;
    assign bus.out_tag          = out_tag;
    assign bus.mispredict_count = cnt_q;
endmodule
